// File: rtl/sample_capture_buffer_pkg.sv
// Shared types and widths for the PDH sample capture buffer.
package pdh_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  localparam int SAMPLE_W         = 16;
  localparam int SAMPLES_PER_WORD = 4;
  localparam int WORD_W           = 64;

endpackage

// File: rtl/sample_capture_buffer_if.sv
// Sample stream in, DMA-side BRAM read port out.
interface sample_capture_buffer_if;
  import pdh_capture_pkg::*;

  logic [SAMPLE_W-1:0] sample_i;
  logic                sample_valid_i;
  logic [31:0]         bram_addr_i;
  logic [WORD_W-1:0]   bram_data_o;

  modport master (
    output sample_i,
    output sample_valid_i,
    output bram_addr_i,
    input  bram_data_o
  );

  modport slave (
    input  sample_i,
    input  sample_valid_i,
    input  bram_addr_i,
    output bram_data_o
  );

endinterface

// File: rtl/sample_capture_buffer_bram.sv
// Simple dual-port block RAM: one synchronous write port, one registered
// read-first read port.
module simple_dp_bram #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16384,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read and write in one block so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_capture_buffer.sv
// Triggered burst capture of 16-bit samples, decimated and packed four per
// 64-bit word into block RAM, then drained by the DMA through the read port.
module sample_capture_buffer
  import pdh_capture_pkg::*;
#(
  parameter  int DEPTH   = 16384,
  parameter  int DECIM_W = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               aclk,
  input  logic               rst_i,
  input  logic               arm_i,
  input  logic               trig_i,
  input  logic [DECIM_W-1:0] decim_i,
  output logic               capture_done_o,
  output logic               busy_o,
  output logic [AW:0]        words_o,
  sample_capture_buffer_if.slave bus
);

  capture_state_t     state_q, state_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [DECIM_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]         lane_q, lane_d;
  logic [WORD_W-1:0]  pack_q, pack_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [AW:0]        words_q, words_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               range_q, range_d;

  logic               accept_s;
  logic               we_s;
  logic [WORD_W-1:0]  wdata_s;
  logic [WORD_W-1:0]  ram_rdata_s;

  // Next-state, decimation, lane packing and write generation.
  always_comb begin
    state_d  = state_q;
    decim_d  = decim_q;
    dcnt_d   = dcnt_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    waddr_d  = waddr_q;
    words_d  = words_q;
    accept_s = 1'b0;
    we_s     = 1'b0;
    wdata_s  = pack_q;

    case (state_q)
      IDLE, DONE: begin
        if (arm_i) begin
          state_d = ARMED;
          decim_d = decim_i;
          dcnt_d  = {DECIM_W{1'b0}};
          lane_d  = 2'd0;
          pack_d  = {WORD_W{1'b0}};
          waddr_d = {AW{1'b0}};
          words_d = {(AW+1){1'b0}};
        end else begin
          state_d = state_q;
        end
      end

      ARMED: begin
        if (trig_i) begin
          state_d = CAPTURE;
        end else begin
          state_d = ARMED;
        end
      end

      CAPTURE: begin
        if (bus.sample_valid_i) begin
          accept_s = (dcnt_q == {DECIM_W{1'b0}});
          if (dcnt_q == decim_q) begin
            dcnt_d = {DECIM_W{1'b0}};
          end else begin
            dcnt_d = dcnt_q + {{(DECIM_W-1){1'b0}}, 1'b1};
          end
          if (accept_s) begin
            pack_d[lane_q*SAMPLE_W +: SAMPLE_W] = bus.sample_i;
            // The last lane goes straight to the RAM together with the held lanes.
            if (lane_q == 2'd3) begin
              we_s    = 1'b1;
              wdata_s = {bus.sample_i, pack_q[WORD_W-SAMPLE_W-1:0]};
              waddr_d = waddr_q + {{(AW-1){1'b0}}, 1'b1};
              words_d = words_q + {{AW{1'b0}}, 1'b1};
              lane_d  = 2'd0;
              if (waddr_q == AW'(DEPTH - 1)) begin
                state_d = DONE;
              end else begin
                state_d = CAPTURE;
              end
            end else begin
              lane_d = lane_q + 2'd1;
            end
          end else begin
            lane_d = lane_q;
          end
        end else begin
          dcnt_d = dcnt_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flags follow the next state so they line up with the state register.
  always_comb begin
    busy_d  = (state_d == ARMED) || (state_d == CAPTURE);
    done_d  = (state_d == DONE);
    range_d = (bus.bram_addr_i[31:AW] == {(32-AW){1'b0}});
  end

  // Control and status registers.
  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state_q <= IDLE;
      decim_q <= {DECIM_W{1'b0}};
      dcnt_q  <= {DECIM_W{1'b0}};
      lane_q  <= 2'd0;
      pack_q  <= {WORD_W{1'b0}};
      waddr_q <= {AW{1'b0}};
      words_q <= {(AW+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      waddr_q <= waddr_d;
      words_q <= words_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      range_q <= range_d;
    end
  end

  simple_dp_bram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_bram (
    .clk     (aclk),
    .we_i    (we_s),
    .waddr_i (waddr_q),
    .wdata_i (wdata_s),
    .raddr_i (bus.bram_addr_i[AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  // The range flag is registered alongside the RAM read, so out-of-range
  // addresses and the post-reset cycle both read as zero.
  assign bus.bram_data_o = range_q ? ram_rdata_s : {WORD_W{1'b0}};
  assign capture_done_o  = done_q;
  assign busy_o          = busy_q;
  assign words_o         = words_q;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Table-driven and randomized bench for sample_capture_buffer with a
// queue-based reference model of decimation and packing.
module tb_sample_capture_buffer;

  localparam int DEPTH  = 16;
  localparam int NS     = 4 * DEPTH;
  localparam int BUDGET = 4000;

  logic        aclk = 1'b0;
  logic        rst_i;
  logic        arm_i;
  logic        trig_i;
  logic [15:0] decim_i;
  logic        capture_done_o;
  logic        busy_o;
  logic [4:0]  words_o;

  sample_capture_buffer_if bus ();

  sample_capture_buffer #(
    .DEPTH   (DEPTH),
    .DECIM_W (16)
  ) dut (
    .aclk           (aclk),
    .rst_i          (rst_i),
    .arm_i          (arm_i),
    .trig_i         (trig_i),
    .decim_i        (decim_i),
    .capture_done_o (capture_done_o),
    .busy_o         (busy_o),
    .words_o        (words_o),
    .bus            (bus)
  );

  always #5 aclk = ~aclk;

  // vmode: 0 always valid, 1 toggling, 2 random. dmode: 0 ramp over valid
  // samples, 1 random. amode: 0 plain, 1 arm+trig together, 2 arm mid-capture.
  typedef struct {
    int          decim;
    int          vmode;
    int          dmode;
    int          amode;
    bit          has_exp;
    logic [63:0] w0;
    logic [63:0] w15;
  } vec_t;

  vec_t        vecs [4];
  logic [63:0] model_mem [DEPTH];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic read_word(input logic [31:0] a, output logic [63:0] d);
    bus.bram_addr_i = a;
    tick();
    d = bus.bram_data_o;
  endtask

  task automatic check_all_words(input string name);
    logic [63:0] d;
    for (int a = 0; a < DEPTH; a++) begin
      read_word(32'(a), d);
      check(name, d, model_mem[a]);
    end
  endtask

  task automatic run_capture(input vec_t v);
    logic [15:0] kept [$];
    logic [15:0] ramp;
    logic [63:0] d;
    int          vidx;
    int          cyc;
    bit          valid;
    ramp = 16'd0;
    vidx = 0;
    cyc  = 0;

    decim_i            = 16'(v.decim);
    arm_i              = 1'b1;
    trig_i             = (v.amode == 1);
    bus.sample_valid_i = 1'b1;
    bus.sample_i       = 16'hDEAD;
    tick();
    arm_i  = 1'b0;
    trig_i = 1'b0;
    check("arm_busy", 64'(busy_o), 64'd1);
    check("arm_done_low", 64'(capture_done_o), 64'd0);
    check("arm_words_zero", 64'(words_o), 64'd0);
    decim_i = 16'(v.decim) ^ 16'h0005;

    if (v.amode == 1) begin
      for (int i = 0; i < 8; i++) begin
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = 16'($urandom);
        tick();
      end
      check("armtrig_no_capture_words", 64'(words_o), 64'd0);
      check("armtrig_still_busy", 64'(busy_o), 64'd1);
    end

    // Trigger cycle carries a junk sample that must not be captured.
    trig_i             = 1'b1;
    bus.sample_valid_i = 1'b1;
    bus.sample_i       = 16'hBEEF;
    tick();
    trig_i = 1'b0;

    while (kept.size() < NS && cyc < BUDGET) begin
      case (v.vmode)
        0:       valid = 1'b1;
        1:       valid = (cyc % 2 == 0);
        default: valid = 1'($urandom_range(0, 1));
      endcase
      bus.sample_valid_i = valid;
      bus.sample_i       = (v.dmode == 1) ? 16'($urandom) : ramp;
      arm_i              = (v.amode == 2) && (cyc == 25);
      tick();
      cyc++;
      arm_i = 1'b0;
      if (valid) begin
        if (vidx % (v.decim + 1) == 0) kept.push_back(bus.sample_i);
        vidx++;
        ramp++;
      end
      if (kept.size() < NS) begin
        check("capture_words", 64'(words_o), 64'(kept.size() / 4));
        check("capture_done_low", 64'(capture_done_o), 64'd0);
      end
    end
    bus.sample_valid_i = 1'b0;

    if (kept.size() < NS) begin
      check("capture_timeout", 64'(kept.size()), 64'(NS));
      return;
    end
    check("done_high", 64'(capture_done_o), 64'd1);
    check("done_words", 64'(words_o), 64'(DEPTH));
    check("done_not_busy", 64'(busy_o), 64'd0);

    for (int w = 0; w < DEPTH; w++) begin
      model_mem[w] = {kept[4*w+3], kept[4*w+2], kept[4*w+1], kept[4*w]};
    end

    for (int i = 0; i < 4; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 16'($urandom);
      tick();
    end
    bus.sample_valid_i = 1'b0;
    check("done_hold", 64'(capture_done_o), 64'd1);
    check("done_hold_words", 64'(words_o), 64'(DEPTH));

    check_all_words("read_word");
    if (v.has_exp) begin
      read_word(32'd0, d);
      check("table_word0", d, v.w0);
      read_word(32'(DEPTH - 1), d);
      check("table_word15", d, v.w15);
    end
  endtask

  task automatic reset_mid_capture();
    logic [15:0] s [$];
    decim_i            = 16'd0;
    arm_i              = 1'b1;
    bus.sample_valid_i = 1'b0;
    tick();
    arm_i  = 1'b0;
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 16'h1000 + 16'(i);
      s.push_back(bus.sample_i);
      tick();
    end
    bus.sample_valid_i = 1'b0;
    check("midrst_words_before", 64'(words_o), 64'd2);
    rst_i = 1'b1;
    tick();
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_words", 64'(words_o), 64'd0);
    check("midrst_done", 64'(capture_done_o), 64'd0);
    check("midrst_data", bus.bram_data_o, 64'd0);
    rst_i = 1'b0;
    model_mem[0] = {s[3], s[2], s[1], s[0]};
    model_mem[1] = {s[7], s[6], s[5], s[4]};
    check_all_words("midrst_read");
    for (int i = 0; i < 8; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 16'($urandom);
      tick();
    end
    bus.sample_valid_i = 1'b0;
    check("midrst_idle_words", 64'(words_o), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    vecs[0] = '{decim: 0, vmode: 0, dmode: 0, amode: 1, has_exp: 1'b1,
                w0: 64'h0003_0002_0001_0000, w15: 64'h003F_003E_003D_003C};
    vecs[1] = '{decim: 2, vmode: 1, dmode: 0, amode: 2, has_exp: 1'b1,
                w0: 64'h0009_0006_0003_0000, w15: 64'h00BD_00BA_00B7_00B4};
    vecs[2] = '{decim: 1, vmode: 2, dmode: 1, amode: 0, has_exp: 1'b0,
                w0: 64'd0, w15: 64'd0};
    vecs[3] = '{decim: 0, vmode: 2, dmode: 1, amode: 0, has_exp: 1'b0,
                w0: 64'd0, w15: 64'd0};

    rst_i              = 1'b1;
    arm_i              = 1'b0;
    trig_i             = 1'b0;
    decim_i            = 16'd0;
    bus.sample_i       = 16'd0;
    bus.sample_valid_i = 1'b0;
    bus.bram_addr_i    = 32'd0;
    tick();
    tick();
    check("reset_done", 64'(capture_done_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_words", 64'(words_o), 64'd0);
    check("reset_data", bus.bram_data_o, 64'd0);
    rst_i           = 1'b0;
    bus.bram_addr_i = 32'(DEPTH);

    for (int i = 0; i < 6; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 16'($urandom);
      trig_i             = 1'b1;
      tick();
    end
    trig_i = 1'b0;
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_words", 64'(words_o), 64'd0);

    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    check("armed_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 30; i++) begin
      bus.sample_valid_i = 1'b1;
      bus.sample_i       = 16'($urandom);
      tick();
    end
    check("armed_words", 64'(words_o), 64'd0);
    check("armed_still_busy", 64'(busy_o), 64'd1);
    check("armed_not_done", 64'(capture_done_o), 64'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_from_armed", 64'(busy_o), 64'd0);

    for (int t = 0; t < 4; t++) begin
      run_capture(vecs[t]);
    end

    read_word(32'(DEPTH), d);
    check("oor_depth", d, 64'd0);
    read_word(32'h8000_0000, d);
    check("oor_high_bit", d, 64'd0);
    read_word(32'h0001_0003, d);
    check("oor_mid_bit", d, 64'd0);
    read_word(32'd3, d);
    check("inrange_after_oor", d, model_mem[3]);

    reset_mid_capture();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
